// File: rtl/counter_gate_ctrl.sv
// counter_gate_ctrl: gate-window controller for an external input counter.
// Each measurement is a one-cycle counter clear, then a gate window of
// i_gate_len cycles. The external count is captured on the edge that
// closes the window. Captures are handed to a consumer through a
// valid/ready pair. A sticky flag records captures that overwrote an
// unread result.
module counter_gate_ctrl #(
    parameter int CW = 32,
    parameter int TW = 32
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_continuous,
    input  logic [TW-1:0] i_gate_len,
    input  logic [CW-1:0] i_count,
    input  logic          i_ready,
    output logic          o_gate,
    output logic          o_cnt_clr,
    output logic [CW-1:0] o_result,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic [TW-1:0] gate_len_eff;
    logic          last_gate_cycle;
    logic          capture;
    logic          start_accept;

    // A zero length still opens the gate for one cycle, so every window
    // produces exactly one capture.
    assign gate_len_eff    = (i_gate_len == '0) ? TW'(1) : i_gate_len;

    // The timer holds the number of gate cycles left, including the
    // current one. The cycle where it reads 1 is the last one.
    assign last_gate_cycle = (state == GATE) && (timer == TW'(1));

    // Abort wins over a capture that would happen on the same edge.
    assign capture         = last_gate_cycle && !i_abort;

    // Abort also wins over a start request presented in IDLE.
    assign start_accept    = (state == IDLE) && i_start && !i_abort;

    // Measurement sequencer: walks IDLE -> CLEAR -> GATE and drives the registered gate, clear and busy outputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= IDLE;
            timer     <= '0;
            o_gate    <= 1'b0;
            o_cnt_clr <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_gate <= 1'b0;
                    if (start_accept) begin
                        state     <= CLEAR;
                        o_cnt_clr <= 1'b1;
                        o_busy    <= 1'b1;
                    end else begin
                        o_cnt_clr <= 1'b0;
                        o_busy    <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (i_abort) begin
                        state     <= IDLE;
                        o_gate    <= 1'b0;
                        o_cnt_clr <= 1'b0;
                        o_busy    <= 1'b0;
                    end else begin
                        // The window length is sampled here only. Later
                        // changes to i_gate_len wait for the next clear.
                        timer     <= gate_len_eff;
                        state     <= GATE;
                        o_gate    <= 1'b1;
                        o_cnt_clr <= 1'b0;
                        o_busy    <= 1'b1;
                    end
                end

                GATE: begin
                    if (i_abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        o_gate    <= 1'b0;
                        o_cnt_clr <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (last_gate_cycle) begin
                        timer  <= '0;
                        o_gate <= 1'b0;
                        if (i_continuous) begin
                            // Back-to-back windows: the clear cycle is the
                            // only gap, so the period is gate_len + 1.
                            state     <= CLEAR;
                            o_cnt_clr <= 1'b1;
                            o_busy    <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            o_cnt_clr <= 1'b0;
                            o_busy    <= 1'b0;
                        end
                    end else begin
                        timer     <= timer - TW'(1);
                        o_gate    <= 1'b1;
                        o_cnt_clr <= 1'b0;
                        o_busy    <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    o_gate    <= 1'b0;
                    o_cnt_clr <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Result register with valid/ready handoff and the sticky overrun flag
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (capture) begin
                o_result <= i_count;
                o_valid  <= 1'b1;
                // A capture landing on the edge where the consumer takes
                // the old result does not lose data. Only an unread
                // result that is overwritten counts as an overrun.
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else begin
                if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
                if (start_accept) begin
                    o_overrun <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_gate_ctrl.sv
// Testbench for counter_gate_ctrl. A behavioural input counter is cleared
// by o_cnt_clr and advances by a programmable step while o_gate is high.
// This lets each capture be predicted from the window length alone.
module tb_counter_gate_ctrl;

    localparam int CW = 32;
    localparam int TW = 8;

    logic          clk        = 1'b0;
    logic          rstn       = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          continuous = 1'b0;
    logic          ready      = 1'b0;
    logic [TW-1:0] gate_len   = '0;
    logic [CW-1:0] count      = '0;

    logic          gate;
    logic          cnt_clr;
    logic [CW-1:0] result;
    logic          valid;
    logic          busy;
    logic          overrun;

    int            inc   = 1;
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] sb_q[$];

    typedef struct {
        logic [TW-1:0] len;
        int            step;
        logic [CW-1:0] exp_result;
        int            exp_gate;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    counter_gate_ctrl #(.CW(CW), .TW(TW)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_abort      (abort),
        .i_continuous (continuous),
        .i_gate_len   (gate_len),
        .i_count      (count),
        .i_ready      (ready),
        .o_gate       (gate),
        .o_cnt_clr    (cnt_clr),
        .o_result     (result),
        .o_valid      (valid),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream input counter
    always @(posedge clk) begin
        if (cnt_clr)
            count <= '0;
        else if (gate)
            count <= count + CW'(inc);
    end

    // Stop the run if the bench itself wedges
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkScoreboard(input string name);
        logic [CW-1:0] exp;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, result);
        end else begin
            exp = sb_q.pop_front();
            checkOutput(name, result, exp);
        end
    endtask

    // One single-shot measurement: start, wait for the capture, check it, consume it
    task automatic applyStimulus(input vec_t v);
        int lat;
        int gcnt;
        gate_len   = v.len;
        inc        = v.step;
        continuous = 1'b0;
        ready      = 1'b0;
        start      = 1'b1;
        sb_q.push_back(v.exp_result);
        tick();
        start = 1'b0;
        lat   = 1;
        gcnt  = 0;
        checkOutput("shot_clear_pulse", cnt_clr, 1'b1);
        checkOutput("shot_gate_in_clear", gate, 1'b0);
        checkOutput("shot_busy_in_clear", busy, 1'b1);
        while (!valid && lat < 300) begin
            tick();
            lat++;
            if (gate) gcnt++;
            if (lat == 3) gate_len = 8'd200;
        end
        checkOutput("shot_valid_seen", valid, 1'b1);
        checkOutput("shot_latency", lat, v.exp_lat);
        checkOutput("shot_gate_cycles", gcnt, v.exp_gate);
        checkScoreboard("shot_result");
        checkOutput("shot_idle_after", busy, 1'b0);
        checkOutput("shot_no_overrun", overrun, 1'b0);
        ready = 1'b1;
        tick();
        checkOutput("shot_valid_consumed", valid, 1'b0);
        ready = 1'b0;
    endtask

    initial begin
        int captures;

        vecs[0] = '{8'd5, 1,   32'd4,   5, 7};
        vecs[1] = '{8'd0, 1,   32'd0,   1, 3};
        vecs[2] = '{8'd1, 4,   32'd0,   1, 3};
        vecs[3] = '{8'd3, 7,   32'd14,  3, 5};
        vecs[4] = '{8'd8, 2,   32'd14,  8, 10};
        vecs[5] = '{8'd2, 100, 32'd100, 2, 4};

        // Reset holds everything low even with a start request present
        rstn     = 1'b0;
        start    = 1'b1;
        gate_len = 8'd5;
        repeat (2) tick();
        checkOutput("rst_gate", gate, 1'b0);
        checkOutput("rst_cnt_clr", cnt_clr, 1'b0);
        checkOutput("rst_valid", valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_result", result, '0);
        start = 1'b0;
        rstn  = 1'b1;
        tick();

        // Table of single-shot windows
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
        end

        // Continuous mode, consumer always ready, four windows of length 3
        gate_len   = 8'd3;
        inc        = 1;
        continuous = 1'b1;
        ready      = 1'b1;
        start      = 1'b1;
        repeat (4) sb_q.push_back(32'd2);
        captures = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                checkOutput($sformatf("cont_gate_%0d", i), gate, (i % 4) != 0);
                checkOutput($sformatf("cont_clr_%0d", i), cnt_clr, (i % 4) == 0);
            end
            if (valid) begin
                captures++;
                checkScoreboard("cont_result");
            end
            if (i == 15) continuous = 1'b0;
            if (i < 16) tick();
        end
        checkOutput("cont_captures", captures, 4);
        checkOutput("cont_overrun", overrun, 1'b0);
        checkOutput("cont_idle_after", busy, 1'b0);
        tick();
        checkOutput("cont_valid_consumed", valid, 1'b0);
        ready = 1'b0;

        // Overrun: two captures in continuous mode with nobody reading
        gate_len   = 8'd2;
        inc        = 1;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("ovr_first_valid", valid, 1'b1);
        checkOutput("ovr_first_result", result, 32'd1);
        checkOutput("ovr_first_no_flag", overrun, 1'b0);
        inc = 5;
        tick();
        continuous = 1'b0;
        tick();
        tick();
        checkOutput("ovr_second_result", result, 32'd5);
        checkOutput("ovr_second_valid", valid, 1'b1);
        checkOutput("ovr_flag_set", overrun, 1'b1);
        checkOutput("ovr_idle", busy, 1'b0);

        // Start together with abort in IDLE is refused and leaves the flag alone
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("startabort_idle", busy, 1'b0);
        checkOutput("startabort_no_clr", cnt_clr, 1'b0);
        checkOutput("startabort_flag_kept", overrun, 1'b1);

        // Accepted start clears overrun; capture coinciding with ready keeps valid high with no overrun
        gate_len = 8'd2;
        inc      = 3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_overrun_clear", overrun, 1'b0);
        checkOutput("restart_busy", busy, 1'b1);
        checkOutput("restart_old_valid", valid, 1'b1);
        tick();
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("coincide_valid", valid, 1'b1);
        checkOutput("coincide_result", result, 32'd3);
        checkOutput("coincide_no_overrun", overrun, 1'b0);

        // Abort in the second gate cycle of a 10-cycle window
        gate_len = 8'd10;
        inc      = 1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("abort_gate_before", gate, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_gate_low", gate, 1'b0);
        checkOutput("abort_idle", busy, 1'b0);
        checkOutput("abort_valid_kept", valid, 1'b1);
        checkOutput("abort_result_kept", result, 32'd3);
        repeat (12) tick();
        checkOutput("abort_no_late_capture", result, 32'd3);
        checkOutput("abort_still_idle", busy, 1'b0);

        // Reset pulse in the middle of a gate window
        gate_len = 8'd6;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checkOutput("midrst_gate", gate, 1'b0);
        checkOutput("midrst_cnt_clr", cnt_clr, 1'b0);
        checkOutput("midrst_valid", valid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_overrun", overrun, 1'b0);
        checkOutput("midrst_result", result, '0);
        repeat (8) tick();
        checkOutput("midrst_no_capture", valid, 1'b0);
        checkOutput("midrst_stays_idle", busy, 1'b0);
        applyStimulus('{8'd4, 2, 32'd6, 4, 6});

        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_gate_ctrl.md
COUNTER_GATE_CTRL -- requirements
Module: counter_gate_ctrl

Interface
REQ-001 SHALL have parameter CW, default 32: width of the count being captured.
REQ-002 SHALL have parameter TW, default 32: width of the gate-length timer.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rstn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_start, input, 1: start-measurement request, sampled in IDLE only.
REQ-006 SHALL have port i_abort, input, 1: abort the current measurement.
REQ-007 SHALL have port i_continuous, input, 1: when 1, windows repeat back-to-back.
REQ-008 SHALL have port i_gate_len, input, TW: gate window length in cycles.
REQ-009 SHALL have port i_count, input, CW: running count from the downstream input counter.
REQ-010 SHALL have port i_ready, input, 1: result consumer accepts o_result.
REQ-011 SHALL have port o_gate, output, 1: gate to the input counter.
REQ-012 SHALL have port o_cnt_clr, output, 1: one-cycle clear pulse to the input counter.
REQ-013 SHALL have port o_result, output, CW: captured count.
REQ-014 SHALL have port o_valid, output, 1: o_result holds an unconsumed capture.
REQ-015 SHALL have port o_busy, output, 1: FSM not in IDLE.
REQ-016 SHALL have port o_overrun, output, 1: sticky flag, an unconsumed result was overwritten.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR and GATE; all outputs are registered.
REQ-018 IDLE SHALL move to CLEAR when i_start=1 and i_abort=0.
REQ-019 CLEAR SHALL last exactly 1 cycle, with o_cnt_clr=1 and o_gate=0.
REQ-020 In CLEAR, the block SHALL latch i_gate_len into the timer; a value of 0 SHALL be treated as 1.
REQ-021 GATE SHALL hold o_gate=1 for exactly the latched number of cycles, counting the timer down by one per cycle.
REQ-022 On the clock edge ending the last GATE cycle, the block SHALL:
  - capture i_count into o_result;
  - set o_valid=1;
  - deassert o_gate.
REQ-023 After the capture, the FSM SHALL go to CLEAR if i_continuous=1, else to IDLE.
REQ-024 Window period in continuous mode SHALL be gate_len+1 cycles.
REQ-025 Changes to i_gate_len SHALL take effect only at the next CLEAR.
REQ-026 Latency from i_start (sampled in IDLE) to o_gate=1 SHALL be 2 cycles.
REQ-027 Latency from i_start to o_valid=1 SHALL be gate_len+2 cycles.
REQ-028 i_abort=1 in CLEAR or GATE SHALL return the FSM to IDLE on the next edge, with o_gate=0, no capture, and o_valid unchanged.
REQ-029 i_abort SHALL take priority over i_start and over a simultaneous capture.
REQ-030 o_valid SHALL clear on any edge where o_valid=1 and i_ready=1 and no capture occurs.
REQ-031 When a capture and i_ready=1 coincide, o_valid SHALL stay 1 with the new data, and o_overrun SHALL NOT set.
REQ-032 When a capture occurs with o_valid=1 and i_ready=0, o_result SHALL be overwritten and o_overrun SHALL set to 1.
REQ-033 o_overrun SHALL clear only on reset, or on the edge that accepts i_start in IDLE.
REQ-034 o_busy SHALL be 1 in CLEAR and GATE, and 0 in IDLE.
REQ-035 i_start outside IDLE SHALL be ignored.
REQ-036 o_result SHALL hold its value when not capturing, and SHALL NOT be altered by i_count between captures.

Reset
REQ-037 While i_rstn=0 at a clock edge, the block SHALL set:
  - state to IDLE;
  - o_gate=0, o_cnt_clr=0, o_valid=0, o_overrun=0, o_busy=0;
  - o_result=0;
  - timer=0.
REQ-038 Reset asserted mid-window SHALL terminate the window with no capture; the first edge after i_rstn=1 SHALL behave as IDLE.

Verification
REQ-039 Single shot: gate_len=5, i_count ramps +1/cycle from 0 at gate rise -> o_gate high 5 cycles, o_result=4, o_valid rises 7 cycles after i_start.
REQ-040 Zero length: gate_len=0, i_start -> o_gate high exactly 1 cycle, one capture, o_valid=1.
REQ-041 Continuous with i_ready=1: gate_len=3, run 4 windows -> gate pattern 0,1,1,1 repeating, o_cnt_clr pulses every 4 cycles, 4 captures, o_overrun=0.
REQ-042 Overrun: continuous mode, i_ready=0 for two captures -> o_result equals second capture, o_overrun=1; o_overrun clears on next accepted i_start.
REQ-043 Abort: i_abort in GATE cycle 2 of 10 -> o_gate=0 next edge, state IDLE, o_valid unchanged; i_start+i_abort together in IDLE -> stays IDLE.
REQ-044 Reset mid-GATE: i_rstn=0 for 1 cycle -> all outputs at reset values, no capture, and a fresh i_start works normally.
